// File: rtl/mips_decls_p.sv
// Shared MIPS declarations: opcode/funct types, multicycle control state and control-word bundle.
package mips_decls_p;

  localparam int unsigned OP_W    = 6;
  localparam int unsigned FUNCT_W = 6;
  localparam int unsigned STATE_W = 4;

  typedef logic [OP_W-1:0]    opcode_t;
  typedef logic [FUNCT_W-1:0] funct_t;

  localparam opcode_t OP_RTYPE = 6'b000000;
  localparam opcode_t OP_J     = 6'b000010;
  localparam opcode_t OP_JAL   = 6'b000011;
  localparam opcode_t OP_BEQ   = 6'b000100;
  localparam opcode_t OP_ADDI  = 6'b001000;
  localparam opcode_t OP_LW    = 6'b100011;
  localparam opcode_t OP_SW    = 6'b101011;

  localparam funct_t FUNCT_JR = 6'b001000;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11,
    S_JALEX   = 4'd12,
    S_JREX    = 4'd13
  } mcstate_t;

  // Every datapath control signal driven by the multicycle controller.
  typedef struct packed {
    logic       pcwrite;
    logic       branch;
    logic       irwrite;
    logic       iord;
    logic       memwrite;
    logic       regwrite;
    logic [1:0] regdst;
    logic [1:0] memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '0;

  // Opcodes this controller knows how to sequence.
  function automatic logic op_supported(input opcode_t op);
    return (op == OP_RTYPE) || (op == OP_J) || (op == OP_JAL) || (op == OP_BEQ) ||
           (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mc_outdec.sv
// Moore output decode: current multicycle state to the full datapath control word.
module mc_outdec
  import mips_decls_p::*;
(
  input  mcstate_t state,
  output ctrl_t    ctrl_c
);

  always_comb begin
    ctrl_c = CTRL_NONE;
    case (state)
      S_FETCH: begin
        ctrl_c.irwrite = 1'b1;
        ctrl_c.pcwrite = 1'b1;
        ctrl_c.alusrcb = 2'b01;
      end
      S_DECODE: begin
        ctrl_c.alusrcb = 2'b11;
      end
      S_MEMADR: begin
        ctrl_c.alusrca = 1'b1;
        ctrl_c.alusrcb = 2'b10;
      end
      S_MEMRD: begin
        ctrl_c.iord = 1'b1;
      end
      S_MEMWB: begin
        ctrl_c.regwrite = 1'b1;
        ctrl_c.memtoreg = 2'b01;
        ctrl_c.regdst   = 2'b00;
      end
      S_MEMWR: begin
        ctrl_c.iord     = 1'b1;
        ctrl_c.memwrite = 1'b1;
      end
      S_RTYPEEX: begin
        ctrl_c.alusrca = 1'b1;
        ctrl_c.aluop   = 2'b10;
      end
      S_RTYPEWB: begin
        ctrl_c.regwrite = 1'b1;
        ctrl_c.regdst   = 2'b01;
      end
      S_BEQEX: begin
        ctrl_c.alusrca = 1'b1;
        ctrl_c.aluop   = 2'b01;
        ctrl_c.branch  = 1'b1;
        ctrl_c.pcsrc   = 2'b01;
      end
      S_ADDIEX: begin
        ctrl_c.alusrca = 1'b1;
        ctrl_c.alusrcb = 2'b10;
      end
      S_ADDIWB: begin
        ctrl_c.regwrite = 1'b1;
        ctrl_c.regdst   = 2'b00;
      end
      S_JEX: begin
        ctrl_c.pcwrite = 1'b1;
        ctrl_c.pcsrc   = 2'b10;
      end
      // PC already holds PC+4 from fetch, so memtoreg=10 links the return address.
      S_JALEX: begin
        ctrl_c.pcwrite  = 1'b1;
        ctrl_c.pcsrc    = 2'b10;
        ctrl_c.regwrite = 1'b1;
        ctrl_c.regdst   = 2'b10;
        ctrl_c.memtoreg = 2'b10;
      end
      S_JREX: begin
        ctrl_c.pcwrite = 1'b1;
        ctrl_c.pcsrc   = 2'b11;
      end
      default: ctrl_c = CTRL_NONE;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS controller: state register, next-state logic and illegal-opcode flag.
// Optional MC_MEM_WAIT_EN adds mem_ready to stall fetch and data-memory states.
module mc_ctrl_fsm
  import mips_decls_p::*;
#(
  parameter mcstate_t RESET_STATE = S_FETCH
) (
  input  logic       clk,
  input  logic       reset_n,
`ifdef MC_MEM_WAIT_EN
  input  logic       mem_ready,
`endif
  input  opcode_t    opcode,
  input  funct_t     funct,
  output logic       pcwrite,
  output logic       branch,
  output logic       irwrite,
  output logic       iord,
  output logic       memwrite,
  output logic       regwrite,
  output logic [1:0] regdst,
  output logic [1:0] memtoreg,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic [1:0] pcsrc,
  output logic       illegal_op,
  output mcstate_t   state
);

  mcstate_t next_state;
  logic     illegal_c;
  logic     mem_wait_c;
  ctrl_t    dec_c;
  ctrl_t    ctrl_c;

  // Memory-facing states hold until the memory acknowledges.
`ifdef MC_MEM_WAIT_EN
  assign mem_wait_c = !mem_ready &&
                      ((state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR));
`else
  assign mem_wait_c = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= RESET_STATE;
      illegal_op <= 1'b0;
    end else begin
      state      <= next_state;
      illegal_op <= illegal_c;
    end
  end

  always_comb begin
    next_state = S_FETCH;
    illegal_c  = 1'b0;
    case (state)
      S_FETCH:  next_state = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_RTYPE:     next_state = (funct == FUNCT_JR) ? S_JREX : S_RTYPEEX;
          OP_BEQ:       next_state = S_BEQEX;
          OP_ADDI:      next_state = S_ADDIEX;
          OP_J:         next_state = S_JEX;
          OP_JAL:       next_state = S_JALEX;
          default: begin
            next_state = S_FETCH;
            illegal_c  = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        if (opcode == OP_LW)      next_state = S_MEMRD;
        else if (opcode == OP_SW) next_state = S_MEMWR;
        else                      next_state = S_FETCH;
      end
      S_MEMRD:   next_state = S_MEMWB;
      S_RTYPEEX: next_state = S_RTYPEWB;
      S_ADDIEX:  next_state = S_ADDIWB;
      S_MEMWB, S_MEMWR, S_RTYPEWB, S_BEQEX, S_ADDIWB, S_JEX, S_JALEX, S_JREX:
                 next_state = S_FETCH;
      default:   next_state = S_FETCH;
    endcase
    if (mem_wait_c) next_state = state;
  end

  mc_outdec u_outdec (
    .state  (state),
    .ctrl_c (dec_c)
  );

  // Strobes are withheld while stalled; mux selects stay put.
  always_comb begin
    ctrl_c = dec_c;
    if (mem_wait_c) begin
      ctrl_c.pcwrite  = 1'b0;
      ctrl_c.irwrite  = 1'b0;
      ctrl_c.memwrite = 1'b0;
    end
  end

  assign pcwrite  = ctrl_c.pcwrite;
  assign branch   = ctrl_c.branch;
  assign irwrite  = ctrl_c.irwrite;
  assign iord     = ctrl_c.iord;
  assign memwrite = ctrl_c.memwrite;
  assign regwrite = ctrl_c.regwrite;
  assign regdst   = ctrl_c.regdst;
  assign memtoreg = ctrl_c.memtoreg;
  assign alusrca  = ctrl_c.alusrca;
  assign alusrcb  = ctrl_c.alusrcb;
  assign aluop    = ctrl_c.aluop;
  assign pcsrc    = ctrl_c.pcsrc;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Randomized instruction-stream bench for mc_ctrl_fsm against a per-instruction state/control model.
module tb_mc_ctrl_fsm;
  import mips_decls_p::*;

  localparam int K_LW = 0, K_SW = 1, K_RT = 2, K_JR = 3, K_BEQ = 4,
                 K_ADDI = 5, K_J = 6, K_JAL = 7, K_ILL = 8;

  logic       clk = 1'b0;
  logic       reset_n;
  opcode_t    opcode;
  funct_t     funct;
  logic       pcwrite, branch, irwrite, iord, memwrite, regwrite, alusrca, illegal_op;
  logic [1:0] regdst, memtoreg, alusrcb, aluop, pcsrc;
  mcstate_t   state;
`ifdef MC_MEM_WAIT_EN
  logic       mem_ready;
  localparam bit WAITS_ON = 1'b1;
`else
  localparam bit WAITS_ON = 1'b0;
`endif

  int   checks = 0;
  int   errors = 0;
  logic ill_pending = 1'b0;

  mc_ctrl_fsm dut (
    .clk        (clk),
    .reset_n    (reset_n),
`ifdef MC_MEM_WAIT_EN
    .mem_ready  (mem_ready),
`endif
    .opcode     (opcode),
    .funct      (funct),
    .pcwrite    (pcwrite),
    .branch     (branch),
    .irwrite    (irwrite),
    .iord       (iord),
    .memwrite   (memwrite),
    .regwrite   (regwrite),
    .regdst     (regdst),
    .memtoreg   (memtoreg),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .aluop      (aluop),
    .pcsrc      (pcsrc),
    .illegal_op (illegal_op),
    .state      (state)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_ready(input logic v);
`ifdef MC_MEM_WAIT_EN
    mem_ready = v;
`else
    if (v) ;
`endif
  endtask

  // Control word the specification lists for each state.
  function automatic ctrl_t spec_ctrl(input mcstate_t s);
    ctrl_t c = '0;
    case (s)
      S_FETCH:   begin c.irwrite = 1; c.pcwrite = 1; c.alusrcb = 2'b01; end
      S_DECODE:  c.alusrcb = 2'b11;
      S_MEMADR:  begin c.alusrca = 1; c.alusrcb = 2'b10; end
      S_MEMRD:   c.iord = 1;
      S_MEMWB:   begin c.regwrite = 1; c.memtoreg = 2'b01; end
      S_MEMWR:   begin c.iord = 1; c.memwrite = 1; end
      S_RTYPEEX: begin c.alusrca = 1; c.aluop = 2'b10; end
      S_RTYPEWB: begin c.regwrite = 1; c.regdst = 2'b01; end
      S_BEQEX:   begin c.alusrca = 1; c.aluop = 2'b01; c.branch = 1; c.pcsrc = 2'b01; end
      S_ADDIEX:  begin c.alusrca = 1; c.alusrcb = 2'b10; end
      S_ADDIWB:  c.regwrite = 1;
      S_JEX:     begin c.pcwrite = 1; c.pcsrc = 2'b10; end
      S_JALEX:   begin c.pcwrite = 1; c.pcsrc = 2'b10; c.regwrite = 1;
                       c.regdst = 2'b10; c.memtoreg = 2'b10; end
      S_JREX:    begin c.pcwrite = 1; c.pcsrc = 2'b11; end
      default:   c = '0;
    endcase
    return c;
  endfunction

  function automatic ctrl_t observed();
    ctrl_t c;
    c.pcwrite  = pcwrite;
    c.branch   = branch;
    c.irwrite  = irwrite;
    c.iord     = iord;
    c.memwrite = memwrite;
    c.regwrite = regwrite;
    c.regdst   = regdst;
    c.memtoreg = memtoreg;
    c.alusrca  = alusrca;
    c.alusrcb  = alusrcb;
    c.aluop    = aluop;
    c.pcsrc    = pcsrc;
    return c;
  endfunction

  task automatic pick(input int kind, output opcode_t op, output funct_t fn);
    fn = funct_t'($urandom);
    case (kind)
      K_LW:   op = OP_LW;
      K_SW:   op = OP_SW;
      K_RT:   begin op = OP_RTYPE; while (fn == 6'b001000) fn = funct_t'($urandom); end
      K_JR:   begin op = OP_RTYPE; fn = 6'b001000; end
      K_BEQ:  op = OP_BEQ;
      K_ADDI: op = OP_ADDI;
      K_J:    op = OP_J;
      K_JAL:  op = OP_JAL;
      default: begin
        op = opcode_t'($urandom);
        while (op inside {6'b000000, 6'b000010, 6'b000011, 6'b000100,
                          6'b001000, 6'b100011, 6'b101011})
          op = opcode_t'($urandom);
      end
    endcase
  endtask

  // Runs one instruction from its fetch cycle; fetch_wait < 0 means random stall length.
  task automatic run_instr(input int kind, input int fetch_wait);
    mcstate_t path[$];
    opcode_t  op;
    funct_t   fn;
    ctrl_t    exp;
    int       nreg = 0;
    int       nmem = 0;
    pick(kind, op, fn);
    opcode = op;
    funct  = fn;
    case (kind)
      K_LW:    path = {S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB};
      K_SW:    path = {S_FETCH, S_DECODE, S_MEMADR, S_MEMWR};
      K_RT:    path = {S_FETCH, S_DECODE, S_RTYPEEX, S_RTYPEWB};
      K_JR:    path = {S_FETCH, S_DECODE, S_JREX};
      K_BEQ:   path = {S_FETCH, S_DECODE, S_BEQEX};
      K_ADDI:  path = {S_FETCH, S_DECODE, S_ADDIEX, S_ADDIWB};
      K_J:     path = {S_FETCH, S_DECODE, S_JEX};
      K_JAL:   path = {S_FETCH, S_DECODE, S_JALEX};
      default: path = {S_FETCH, S_DECODE};
    endcase
    foreach (path[i]) begin
      int nw = 0;
      if (WAITS_ON && (path[i] inside {S_FETCH, S_MEMRD, S_MEMWR}))
        nw = (i == 0 && fetch_wait >= 0) ? fetch_wait : int'($urandom_range(0, 2));
      for (int w = 0; w <= nw; w++) begin
        set_ready(w == nw);
        #1;
        exp = spec_ctrl(path[i]);
        if (w < nw) begin
          exp.pcwrite  = 1'b0;
          exp.irwrite  = 1'b0;
          exp.memwrite = 1'b0;
        end
        check($sformatf("state k%0d c%0d", kind, i), 32'(state), 32'(path[i]));
        check($sformatf("ctrl %s w%0d", path[i].name(), w), 32'(observed()), 32'(exp));
        check("illegal_op", 32'(illegal_op), 32'((i == 0 && w == 0) ? ill_pending : 1'b0));
        nreg += int'(regwrite);
        nmem += int'(memwrite);
        @(posedge clk);
        #1;
      end
    end
    ill_pending = (kind == K_ILL);
    check($sformatf("regwrite cycles k%0d", kind), 32'(nreg),
          32'((kind inside {K_LW, K_RT, K_ADDI, K_JAL}) ? 1 : 0));
    check($sformatf("memwrite cycles k%0d", kind), 32'(nmem), 32'((kind == K_SW) ? 1 : 0));
  endtask

  // Asynchronous reset in the middle of a load's memory read.
  task automatic reset_in_memrd();
    opcode = OP_LW;
    funct  = '0;
    set_ready(1'b1);
    repeat (3) begin @(posedge clk); #1; end
    check("state before reset", 32'(state), 32'(S_MEMRD));
    reset_n = 1'b0;
    #1;
    check("state async reset", 32'(state), 32'(S_FETCH));
    for (int c = 0; c < 3; c++) begin
      check("regwrite in reset", 32'(regwrite), 32'd0);
      check("memwrite in reset", 32'(memwrite), 32'd0);
      @(posedge clk);
      #1;
      check("state held in reset", 32'(state), 32'(S_FETCH));
    end
    reset_n = 1'b1;
    ill_pending = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    opcode  = OP_LW;
    funct   = '0;
    set_ready(1'b1);
    repeat (3) begin
      @(posedge clk);
      #1;
      check("reset state", 32'(state), 32'(S_FETCH));
      check("reset illegal_op", 32'(illegal_op), 32'd0);
      check("reset ctrl", 32'(observed()), 32'(spec_ctrl(S_FETCH)));
    end
    reset_n = 1'b1;

    run_instr(K_LW, 3);
    run_instr(K_SW, 0);
    run_instr(K_RT, 0);
    run_instr(K_BEQ, 0);
    run_instr(K_J, 0);
    run_instr(K_JAL, 0);
    run_instr(K_JR, 0);
    run_instr(K_ILL, 0);
    run_instr(K_ADDI, 0);
    run_instr(K_ILL, 2);
    run_instr(K_LW, 1);
    reset_in_memrd();
    for (int n = 0; n < 200; n++) run_instr(int'($urandom_range(0, 8)), -1);
    run_instr(K_LW, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
